// File: rtl/tm_lif_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons.
// One slot is visited per enabled clock in round-robin order.
module tm_lif_array #(
  parameter int N_NEURONS  = 4,
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRACT    = 2,
  parameter int IDX_W      = $clog2(N_NEURONS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [WIDTH-1:0]     current_i,
  input  logic [WIDTH-1:0]     thresh_i,
  output logic [IDX_W-1:0]     cur_sel_o,
  output logic                 spike_o,
  output logic [IDX_W-1:0]     spike_idx_o,
  output logic [WIDTH-1:0]     state_o,
  output logic [N_NEURONS-1:0] spike_vec_o,
  output logic                 sweep_done_o
);

  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(N_NEURONS - 1);
  localparam logic [RW-1:0]        REFR_LOAD = RW'(REFRACT);
  localparam logic [N_NEURONS-1:0] ONE_HOT   = N_NEURONS'(1);

  // Unsigned add clamped to the all-ones value instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[WIDTH]) begin
      sat_add = {WIDTH{1'b1}};
    end else begin
      sat_add = s[WIDTH-1:0];
    end
  endfunction

  logic [WIDTH-1:0]     mem_q [N_NEURONS];
  logic [RW-1:0]        refr_q [N_NEURONS];
  logic [IDX_W-1:0]     cur_sel_q;
  logic                 spike_q;
  logic [IDX_W-1:0]     spike_idx_q;
  logic [WIDTH-1:0]     state_q;
  logic [N_NEURONS-1:0] spike_vec_q;
  logic                 sweep_done_q;
  logic [N_NEURONS-1:0] acc_q;

  logic [WIDTH-1:0]     leak_s;
  logic [WIDTH-1:0]     sum_s;
  logic                 fire_s;
  logic                 last_s;
  logic [N_NEURONS-1:0] hit_s;
  logic [WIDTH-1:0]     mem_d;
  logic [RW-1:0]        refr_d;
  logic [IDX_W-1:0]     cur_sel_d;

  // Shared update datapath for the currently selected neuron.
  always_comb begin
    leak_s    = mem_q[cur_sel_q] >> LEAK_SHIFT;
    sum_s     = sat_add(leak_s, current_i);
    fire_s    = 1'b0;
    mem_d     = {WIDTH{1'b0}};
    refr_d    = {RW{1'b0}};
    hit_s     = {N_NEURONS{1'b0}};
    last_s    = (cur_sel_q == LAST_IDX);
    cur_sel_d = {IDX_W{1'b0}};
    // A refractory neuron is held at zero and ignores its input entirely.
    if (refr_q[cur_sel_q] != {RW{1'b0}}) begin
      refr_d = refr_q[cur_sel_q] - RW'(1);
    end else if (sum_s >= thresh_i) begin
      fire_s = 1'b1;
      refr_d = REFR_LOAD;
    end else begin
      mem_d = sum_s;
    end
    if (fire_s) begin
      hit_s = ONE_HOT << cur_sel_q;
    end else begin
      hit_s = {N_NEURONS{1'b0}};
    end
    if (last_s) begin
      cur_sel_d = {IDX_W{1'b0}};
    end else begin
      cur_sel_d = cur_sel_q + IDX_W'(1);
    end
  end

  // Per-neuron membrane and refractory storage; only the visited entry changes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_q[i]  <= {WIDTH{1'b0}};
        refr_q[i] <= {RW{1'b0}};
      end
    end else if (en_i) begin
      mem_q[cur_sel_q]  <= mem_d;
      refr_q[cur_sel_q] <= refr_d;
    end
  end

  // Slot pointer, per-update outputs and sweep framing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_sel_q    <= {IDX_W{1'b0}};
      spike_q      <= 1'b0;
      spike_idx_q  <= {IDX_W{1'b0}};
      state_q      <= {WIDTH{1'b0}};
      spike_vec_q  <= {N_NEURONS{1'b0}};
      sweep_done_q <= 1'b0;
      acc_q        <= {N_NEURONS{1'b0}};
    end else if (en_i) begin
      cur_sel_q    <= cur_sel_d;
      spike_q      <= fire_s;
      spike_idx_q  <= cur_sel_q;
      state_q      <= mem_d;
      sweep_done_q <= last_s;
      if (last_s) begin
        spike_vec_q <= acc_q | hit_s;
        acc_q       <= {N_NEURONS{1'b0}};
      end else begin
        acc_q       <= acc_q | hit_s;
      end
    end else begin
      spike_q      <= 1'b0;
      sweep_done_q <= 1'b0;
    end
  end

  assign cur_sel_o    = cur_sel_q;
  assign spike_o      = spike_q;
  assign spike_idx_o  = spike_idx_q;
  assign state_o      = state_q;
  assign spike_vec_o  = spike_vec_q;
  assign sweep_done_o = sweep_done_q;

endmodule
